// File: rtl/tetris_gravity_ctrl.sv
// Gravity and lock-delay scheduler for the falling piece.
// Divides clk_in into a base tick, emits level-paced fall pulses and
// a single lock request once the lock-delay window expires.
//
// Ports:
//   clk_in       system clock
//   rst_n        asynchronous active-low reset
//   level        game level 0..15, sets the fall period
//   soft_drop    level; selects SOFT_PERIOD while high
//   hard_drop    pulse; lock immediately (FALL/LOCK only)
//   pause        level; freezes all timing, masks pulses
//   piece_spawn  pulse; restart in FALL with counters cleared
//   piece_landed level; piece rests on the stack
//   fall_tick    pulse; move piece down one row
//   lock_pulse   pulse; fix piece into the board
//   state        00 IDLE, 01 FALL, 10 LOCK

module tetris_gravity_ctrl #(
    parameter int TICK_DIV    = 1000000,
    parameter int BASE_PERIOD = 80,
    parameter int STEP        = 8,
    parameter int MIN_PERIOD  = 4,
    parameter int SOFT_PERIOD = 2,
    parameter int LOCK_TICKS  = 50
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic [3:0] level,
    input  logic       soft_drop,
    input  logic       hard_drop,
    input  logic       pause,
    input  logic       piece_spawn,
    input  logic       piece_landed,
    output logic       fall_tick,
    output logic       lock_pulse,
    output logic [1:0] state
);

    localparam int PM0  = (BASE_PERIOD > MIN_PERIOD) ?
                          BASE_PERIOD : MIN_PERIOD;
    localparam int PMAX = (PM0 > SOFT_PERIOD) ?
                          PM0 : SOFT_PERIOD;
    // Headroom for the most negative BASE - 15*STEP result.
    localparam int PW = $clog2(PMAX + 1)
                      + $clog2(15 * STEP + 1) + 2;
    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int LW = $clog2(LOCK_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FALL = 2'b01,
        LOCK = 2'b10
    } state_t;

    state_t          st_q, st_d;
    logic [TW-1:0]   presc_q, presc_d;
    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic [LW-1:0]   lcnt_q, lcnt_d;
    logic            fall_q, fall_d;
    logic            lock_q, lock_d;

    logic                 base_tick;
    logic signed [PW-1:0] lvl_diff;
    logic [PW-1:0]        lvl_period;
    logic [PW-1:0]        period;

    assign base_tick  = (presc_q == TW'(TICK_DIV - 1));
    assign state      = st_q;
    assign fall_tick  = fall_q;
    assign lock_pulse = lock_q;

    // Signed so a high level saturates to MIN_PERIOD.
    always_comb begin
        lvl_diff = $signed(PW'(BASE_PERIOD))
                 - $signed(PW'(level)) * $signed(PW'(STEP));
        if (lvl_diff < $signed(PW'(MIN_PERIOD)))
            lvl_period = PW'(MIN_PERIOD);
        else
            lvl_period = $unsigned(lvl_diff);
        period = soft_drop ? PW'(SOFT_PERIOD) : lvl_period;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= IDLE;
            presc_q <= '0;
            pcnt_q  <= '0;
            lcnt_q  <= '0;
            fall_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            lcnt_q  <= lcnt_d;
            fall_q  <= fall_d;
            lock_q  <= lock_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        presc_d = presc_q;
        pcnt_d  = pcnt_q;
        lcnt_d  = lcnt_q;
        fall_d  = 1'b0;
        lock_d  = 1'b0;

        if (piece_spawn) begin
            st_d    = FALL;
            presc_d = '0;
            pcnt_d  = '0;
            lcnt_d  = '0;
        end else if (pause) begin
            // hold everything; pulses stay low
        end else if (hard_drop && st_q != IDLE) begin
            st_d    = IDLE;
            lock_d  = 1'b1;
            presc_d = '0;
            pcnt_d  = '0;
            lcnt_d  = '0;
        end else begin
            unique case (st_q)
                IDLE: begin
                    presc_d = '0;
                    pcnt_d  = '0;
                    lcnt_d  = '0;
                end
                FALL: begin
                    if (piece_landed) begin
                        st_d    = LOCK;
                        presc_d = '0;
                        pcnt_d  = '0;
                        lcnt_d  = '0;
                    end else begin
                        presc_d = base_tick ?
                                  '0 : presc_q + TW'(1);
                        if (base_tick) begin
                            // >= so a shrunk period fires at once
                            if (pcnt_q + PW'(1) >= period) begin
                                fall_d = 1'b1;
                                pcnt_d = '0;
                            end else begin
                                pcnt_d = pcnt_q + PW'(1);
                            end
                        end
                    end
                end
                LOCK: begin
                    if (!piece_landed) begin
                        st_d    = FALL;
                        presc_d = '0;
                        pcnt_d  = '0;
                        lcnt_d  = '0;
                    end else begin
                        presc_d = base_tick ?
                                  '0 : presc_q + TW'(1);
                        if (base_tick) begin
                            if (lcnt_q + LW'(1) >= LW'(LOCK_TICKS)) begin
                                st_d    = IDLE;
                                lock_d  = 1'b1;
                                presc_d = '0;
                                lcnt_d  = '0;
                            end else begin
                                lcnt_d = lcnt_q + LW'(1);
                            end
                        end
                    end
                end
                default: begin
                    st_d    = IDLE;
                    presc_d = '0;
                    pcnt_d  = '0;
                    lcnt_d  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_gravity_ctrl.sv
// Directed bench for tetris_gravity_ctrl.
// Measures pulse timing in clock cycles against hand-computed values.

module tb_tetris_gravity_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic [3:0] level;
    logic       soft_drop;
    logic       hard_drop;
    logic       pause;
    logic       piece_spawn;
    logic       piece_landed;
    logic       fall_tick;
    logic       lock_pulse;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    tetris_gravity_ctrl #(
        .TICK_DIV   (4),
        .BASE_PERIOD(10),
        .STEP       (2),
        .MIN_PERIOD (3),
        .SOFT_PERIOD(1),
        .LOCK_TICKS (5)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .level       (level),
        .soft_drop   (soft_drop),
        .hard_drop   (hard_drop),
        .pause       (pause),
        .piece_spawn (piece_spawn),
        .piece_landed(piece_landed),
        .fall_tick   (fall_tick),
        .lock_pulse  (lock_pulse),
        .state       (state)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input int got,
                       input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_in);
    endtask

    task automatic spawn();
        piece_spawn = 1'b1;
        @(negedge clk_in);
        piece_spawn = 1'b0;
    endtask

    // Cycles until the selected pulse (0 fall, 1 lock) is seen;
    // also counts pulses of the other kind seen on the way.
    task automatic wait_evt(input int sel, input int lim,
                            output int n, output int other);
        logic hit;
        n = lim + 1;
        other = 0;
        for (int k = 1; k <= lim; k++) begin
            @(negedge clk_in);
            hit = (sel == 0) ? fall_tick : lock_pulse;
            if ((sel == 0) ? lock_pulse : fall_tick) other++;
            if (hit) begin
                n = k;
                break;
            end
        end
    endtask

    int n, oth, extra;

    initial begin
        rst_n = 1'b0;
        level = 4'd0;
        soft_drop = 1'b0;
        hard_drop = 1'b0;
        pause = 1'b0;
        piece_spawn = 1'b0;
        piece_landed = 1'b0;

        #12;
        chk("rst_state", state, 0);
        chk("rst_fall", fall_tick, 0);
        chk("rst_lock", lock_pulse, 0);
        @(negedge clk_in);
        rst_n = 1'b1;
        step(2);
        chk("idle_state", state, 0);

        // 1: level-driven periods
        spawn();
        chk("spawn_state", state, 1);
        for (int i = 0; i < 3; i++) begin
            wait_evt(0, 200, n, oth);
            chk("lvl0_period", n, 40);
        end
        step(1);
        chk("fall_single", fall_tick, 0);
        level = 4'd2;
        spawn();
        for (int i = 0; i < 2; i++) begin
            wait_evt(0, 200, n, oth);
            chk("lvl2_period", n, 24);
        end
        level = 4'd9;
        spawn();
        for (int i = 0; i < 2; i++) begin
            wait_evt(0, 200, n, oth);
            chk("lvl9_sat", n, 12);
        end
        level = 4'd15;
        spawn();
        wait_evt(0, 200, n, oth);
        chk("lvl15_sat", n, 12);

        // 2: soft drop
        level = 4'd0;
        spawn();
        wait_evt(0, 200, n, oth);
        chk("pre_soft", n, 40);
        soft_drop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_evt(0, 200, n, oth);
            chk("soft_period", n, 4);
        end
        soft_drop = 1'b0;
        wait_evt(0, 200, n, oth);
        chk("post_soft", n, 40);

        // 3: lock delay expiry
        piece_landed = 1'b1;
        step(1);
        chk("lock_state", state, 2);
        wait_evt(1, 200, n, oth);
        chk("lock_delay", n, 20);
        chk("lock_nofall", oth, 0);
        chk("lock_to_idle", state, 0);
        step(1);
        chk("lock_single", lock_pulse, 0);
        piece_landed = 1'b0;

        // 4: slide off ledge, then hard drop
        spawn();
        piece_landed = 1'b1;
        step(1);
        chk("lock2_state", state, 2);
        extra = 0;
        for (int i = 0; i < 11; i++) begin
            step(1);
            if (lock_pulse || fall_tick) extra++;
        end
        piece_landed = 1'b0;
        step(1);
        chk("slide_quiet", extra, 0);
        chk("slide_state", state, 1);
        wait_evt(0, 200, n, oth);
        chk("slide_fall", n, 40);
        chk("slide_nolock", oth, 0);
        hard_drop = 1'b1;
        step(1);
        hard_drop = 1'b0;
        chk("hd_lock", lock_pulse, 1);
        chk("hd_state", state, 0);
        chk("hd_nofall", fall_tick, 0);
        step(1);
        chk("hd_single", lock_pulse, 0);

        // 5: pause for 7 cycles with a masked hard drop
        spawn();
        step(10);
        pause = 1'b1;
        step(2);
        hard_drop = 1'b1;
        step(1);
        hard_drop = 1'b0;
        step(4);
        pause = 1'b0;
        chk("pause_state", state, 1);
        chk("pause_nolock", lock_pulse, 0);
        wait_evt(0, 200, n, oth);
        chk("pause_delay", n, 30);
        chk("pause_hd_ign", oth, 0);

        // 6a: hard drop with spawn
        hard_drop = 1'b1;
        piece_spawn = 1'b1;
        step(1);
        hard_drop = 1'b0;
        piece_spawn = 1'b0;
        chk("hdsp_state", state, 1);
        chk("hdsp_nolock", lock_pulse, 0);
        wait_evt(0, 200, n, oth);
        chk("hdsp_fall", n, 40);
        chk("hdsp_nolock2", oth, 0);

        // 6b: asynchronous reset mid-lock
        spawn();
        piece_landed = 1'b1;
        step(6);
        chk("pre_rst_state", state, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_fall", fall_tick, 0);
        chk("arst_lock", lock_pulse, 0);
        @(negedge clk_in);
        piece_landed = 1'b0;
        rst_n = 1'b1;
        step(2);
        chk("post_rst_idle", state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
